// File: rtl/multicycle_sequencer_if.sv
// Handshake and status bundle between the multicycle sequencer and its datapath/memories.
// The sequencer side uses the master modport. The environment (decoder, memories, bench)
// uses the slave modport.
interface multicycle_sequencer_if;
  logic        run;
  logic [6:0]  opcode;
  logic        ctl_regwr;
  logic        ctl_memwr;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        pc_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_err;
  logic [31:0] instret;

  modport master (
    input  run, opcode, ctl_regwr, ctl_memwr, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we,
    output state, illegal, bus_err, instret
  );

  modport slave (
    output run, opcode, ctl_regwr, ctl_memwr, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we,
    input  state, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch / decode / execute / memory / writeback
// control with memory-ack timeouts, sticky error flags and a retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for run; no strobes
// FETCH  | imem_req held until imem_ack; ir_we pulses with the ack
// DECODE | one cycle; unknown opcode traps with illegal set
// EXEC   | one cycle; loads/stores go to MEM, everything else to WB
// MEM    | dmem_req held until dmem_ack; dmem_we follows ctl_memwr
// WB     | one cycle; pc_we, rf_we=ctl_regwr, instret increments
// TRAP   | absorbing; only rst leaves it
module multicycle_sequencer #(
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  multicycle_sequencer_if.master bus
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  // Last wait cycle: still no ack here means the access has timed out.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic           illegal_q, illegal_d;
  logic           bus_err_q, bus_err_d;
  logic [31:0]    instret_q;
  logic           retire;
  logic           imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we;
  logic           legal_op, mem_op;

  assign legal_op = bus.opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                                       7'b0100011, 7'b1100011, 7'b1100111,
                                       7'b1101111, 7'b0010111, 7'b0110111};
  assign mem_op   = (bus.opcode == 7'b0000011) || (bus.opcode == 7'b0100011);

  // Next-state, wait counter, sticky flags and control strobes.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        if (legal_op) begin
          state_d = EXEC;
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (mem_op) begin
          state_d = MEM;
          wait_d  = '0;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.ctl_memwr;
        if (bus.dmem_ack) begin
          state_d = WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        rf_we  = bus.ctl_regwr;
        retire = 1'b1;
        if (bus.run) begin
          state_d = FETCH;
          wait_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // State, counters and flags; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.pc_we    = pc_we;
  assign bus.rf_we    = rf_we;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.bus_err  = bus_err_q;
  assign bus.instret  = instret_q;

endmodule
